// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state encoding and port index type for the memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_AW   = 13;
  localparam int DEF_DW   = 8;
  localparam int DEF_LENW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef logic port_t;

  function automatic logic [1:0] port_onehot(input port_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select (combinational); last-granted pointer registered on accept.
// No backpressure of its own: the caller decides when a grant is taken via accept.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output port_t      winner,
  output logic       any
);

  port_t last;

  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) winner = ~last;
    else              winner = req[1];
  end

  assign any = |req;

  // Reset value 1 hands the first tie to port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                last <= 1'b1;
    else if (accept && any) last <= winner;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory between fetch (port 0) and load/store (port 1); grant 1 cycle after request,
// read data 1 cycle after each read strobe. Requests are held by the ports and ignored while a transaction runs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW,
  parameter int LENW = DEF_LENW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [AW-1:0]   addr0,
  input  logic [AW-1:0]   addr1,
  input  logic [LENW-1:0] len0,
  input  logic [LENW-1:0] len1,
  input  logic [DW-1:0]   wdata0,
  input  logic [DW-1:0]   wdata1,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      done,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wr,
  output logic            mem_write,
  output logic            mem_read,
  input  logic [DW-1:0]   mem_rd
);

  state_t          state, state_n;
  port_t           winner, owner, owner_n;
  logic            any, accept;
  logic [AW-1:0]   base, base_n;
  logic [LENW-1:0] last_beat, last_beat_n;
  logic [LENW-1:0] beat, beat_n;

  logic [1:0]      gnt_n, rvalid_n, done_n;
  logic [DW-1:0]   rdata_n, mem_wr_n;
  logic [AW-1:0]   mem_addr_n;
  logic            mem_write_n, mem_read_n;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    base_n      = base;
    last_beat_n = last_beat;
    beat_n      = beat;
    accept      = 1'b0;
    gnt_n       = '0;
    rvalid_n    = '0;
    done_n      = '0;
    rdata_n     = rdata;
    mem_addr_n  = mem_addr;
    mem_wr_n    = mem_wr;
    mem_write_n = 1'b0;
    mem_read_n  = 1'b0;

    case (state)
      IDLE: begin
        if (any) begin
          accept      = 1'b1;
          owner_n     = winner;
          gnt_n       = port_onehot(winner);
          base_n      = winner ? addr1 : addr0;
          mem_addr_n  = winner ? addr1 : addr0;
          beat_n      = '0;
          if (we[winner]) begin
            last_beat_n = '0;
            mem_wr_n    = winner ? wdata1 : wdata0;
            mem_write_n = 1'b1;
            state_n     = WRITE;
          end else begin
            last_beat_n = winner ? len1 : len0;
            mem_read_n  = 1'b1;
            state_n     = READ;
          end
        end
      end
      READ: begin
        // Byte for the current beat is on mem_rd now; it shows up on rdata next cycle.
        rdata_n  = mem_rd;
        rvalid_n = port_onehot(owner);
        if (beat == last_beat) begin
          done_n  = port_onehot(owner);
          state_n = IDLE;
        end else begin
          beat_n     = beat + 1'b1;
          mem_addr_n = base + AW'(beat_n);
          mem_read_n = 1'b1;
        end
      end
      WRITE: begin
        done_n  = port_onehot(owner);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      base      <= '0;
      last_beat <= '0;
      beat      <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      done      <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wr    <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      base      <= base_n;
      last_beat <= last_beat_n;
      beat      <= beat_n;
      gnt       <= gnt_n;
      rvalid    <= rvalid_n;
      done      <= done_n;
      rdata     <= rdata_n;
      mem_addr  <= mem_addr_n;
      mem_wr    <= mem_wr_n;
      mem_write <= mem_write_n;
      mem_read  <= mem_read_n;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing arbiter that shares the single byte-wide main memory (13-bit address, 8-bit data, `memorywrite`/`memoryread` strobes) between two requesters: port 0 (instruction fetch) and port 1 (data load/store). Requesters are selected round-robin. Reads may be short bursts of consecutive bytes for multi-byte instructions. Writes are single-byte. The block sits between the CPU control/datapath and the memory, and is the only driver of the memory's address, write-data and strobe inputs.

## Interface
- `AW`, 13: memory address width.
- `DW`, 8: data width.
- `LENW`, 2: burst-length field width; burst = `len`+1 bytes (1..4).
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req[1:0]`  in  2: per-port request; held until the matching `gnt` pulse.
- `we[1:0]`  in  2: per-port write enable (1 = single-byte write, 0 = read burst).
- `addr0`, `addr1`  in  AW each: start address per port.
- `len0`, `len1`  in  LENW each: bytes-1 per port; ignored when `we` is set.
- `wdata0`, `wdata1`  in  DW each: write byte per port.
- `gnt[1:0]`  out  2: one-cycle pulse; request accepted and latched.
- `rvalid[1:0]`  out  2: read byte valid on `rdata`, one pulse per beat.
- `rdata`  out  DW: registered read byte, shared by both ports.
- `done[1:0]`  out  2: one-cycle pulse; transaction complete.
- `mem_addr`  out  AW: to memory `addr`.
- `mem_wr`  out  DW: to memory `WR`.
- `mem_write`, `mem_read`  out  1 each: to memory `memorywrite`, `memoryread`.
- `mem_rd`  in  DW: from memory `RD`.

## Operation
- FSM states: IDLE, READ, WRITE.
- IDLE: `req` is sampled. If any bit is set, the winner is chosen and `addr`/`len`/`we`/`wdata` are latched. `gnt[winner]` pulses on the next cycle. The FSM moves to READ or WRITE. `req` is ignored outside IDLE.
- Arbitration: single request wins outright. If both are set, the grant goes to the port not granted last. The `last` pointer updates on every grant. After reset, `last`=1, so port 0 wins the first tie.
- READ: beat counter `b` runs from 0 to `len`. `mem_addr` = latched address + `b`, modulo 2^AW, so 8191 wraps to 0. `mem_read`=1. `mem_rd` is captured into `rdata` every cycle, and `rvalid[owner]` pulses the following cycle. After beat `len`, the FSM returns to IDLE. `done[owner]` coincides with the last `rvalid`.
- WRITE: one cycle with `mem_write`=1, `mem_addr` = latched address and `mem_wr` = latched byte. `done[owner]` pulses the next cycle, then the FSM returns to IDLE.
- `mem_write` and `mem_read` are never high together. Both are 0 in IDLE. `mem_addr` and `mem_wr` hold their last value in IDLE.
- Reset (any time, including mid-burst): the FSM goes to IDLE immediately and the transaction is aborted with no `done`.
  - All outputs clear: `gnt`/`rvalid`/`done`/`mem_write`/`mem_read`=0, `rdata`/`mem_addr`/`mem_wr`=0, `last`=1.
  - Because `mem_write` drops asynchronously, no write occurs on the edge after reset asserts.

## Timing
- Read, request seen in IDLE at cycle t, burst length L = `len`+1:
  - `gnt` and the first `mem_read` at t+1.
  - `mem_read` asserted on cycles t+1..t+L.
  - `rvalid` on cycles t+2..t+L+1; `done` at t+L+1.
  - FSM back in IDLE at t+L+1, where it may sample the next request. The next `gnt` comes at t+L+2.
- Write, request at t: `gnt` and `mem_write` at t+1 (memory updates on the edge ending t+1); `done` at t+2; IDLE at t+2.
- Worst-case wait for a continuously requesting port is one foreign transaction (at most 4 read beats).
- `rdata` is valid only while `rvalid` is set and otherwise holds its last value.

## Structure
- Package `mem_arb_pkg`:
  - `AW`/`DW`/`LENW` defaults.
  - `state_t` enum {IDLE, READ, WRITE}.
  - `port_t` (1-bit port index).
- Sub-module `rr_arbiter2` (combinational winner select from `req` and `last`; registered `last` update on grant). All other logic, including the FSM, beat counter and latches, stays in the top level.

## Test plan
- Port 0 read, addr 0, len 3 -> `gnt[0]` at t+1; `rvalid[0]` ×4 with `rdata` = F0, 03, E7, E8; `done[0]` with the 4th beat.
- Port 1 write 0x5A to 1005, then port 1 read 1005, len 0 -> `mem_write` for exactly 1 cycle; read returns 5A; `done[1]` at t+2 for each.
- Both ports request continuously, single-byte reads -> grants alternate 0,1,0,1 starting with 0; no port is starved.
- Port 0 read at 8190, len 3 -> `mem_addr` sequence 8190, 8191, 0, 1.
- `rst` asserted on the 2nd beat of a 4-beat read -> all outputs 0 in the same cycle; no further `rvalid`/`done`; first post-reset tie goes to port 0.
- Port 1 write requested while port 0 burst is active -> port 1 request ignored until IDLE; `gnt[1]` exactly one cycle after port 0 `done`; `mem_read` and `mem_write` never overlap.
